// File: rtl/l1_pkg.sv
// Shared definitions for the L1 line refill handler.
// The package holds the address split for one cache line unit of 8 x 32-bit
// words, the handler state type and small helpers for slicing addresses.
// Address layout: tag[31:9] | set[8:5] | word[4:2] | offset[1:0].
package l1_pkg;

  localparam int TAG_W      = 23;
  localparam int SET_W      = 4;
  localparam int WORD_W     = 3;
  localparam int LINE_WORDS = 1 << WORD_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
    return a[31 -: TAG_W];
  endfunction

  function automatic logic [SET_W-1:0] addr_set(input logic [31:0] a);
    return a[WORD_W+2 +: SET_W];
  endfunction

  // Word-aligned address of one word of a line.
  function automatic logic [31:0] line_addr(input logic [TAG_W-1:0]  tag,
                                            input logic [SET_W-1:0]  set,
                                            input logic [WORD_W-1:0] word);
    return {tag, set, word, 2'b00};
  endfunction

endpackage

// File: rtl/l1_line_refill_if.sv
// Memory bus between the line refill handler and the memory system.
// One word moves per cycle in which mem_req and mem_ack are both high.
//   mem_req   request (master)
//   mem_we    1 = write, 0 = read (master)
//   mem_addr  word-aligned address (master)
//   mem_wdata write data (master)
//   mem_rdata read data, valid with mem_ack (slave)
//   mem_ack   one word completes this cycle (slave)
interface l1_line_refill_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/l1_line_refill.sv
// Miss handler and metadata owner for one L1 cache line unit.
// On a miss it writes the dirty victim line back over the memory bus (reading
// it through the line's peek port), then refills the line word by word from the
// bus and republishes valid/tag/set. busy stalls the CPU via the controller.
// TAG_W + SET_W + WORD_W + 2 must equal 32.
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   miss_req/addr     refill request, held until done; tag and set of the miss
//   cpu_wr_hit        CPU write hit on this line, marks it dirty
//   busy, done        handler not idle; one-cycle completion pulse
//   valid, my_tag_addr, my_set_addr, dirty   line metadata
//   peek_addr/rdata   victim read port of the line
//   fill_wreq/addr/wdata  full-word write port of the line
//   mem               memory bus master port
module l1_line_refill
  import l1_pkg::*;
#(
  parameter int TAG_W  = l1_pkg::TAG_W,
  parameter int SET_W  = l1_pkg::SET_W,
  parameter int WORD_W = l1_pkg::WORD_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               miss_req,
  input  logic [31:0]        miss_addr,
  input  logic               cpu_wr_hit,
  output logic               busy,
  output logic               done,
  output logic               valid,
  output logic [TAG_W-1:0]   my_tag_addr,
  output logic [SET_W-1:0]   my_set_addr,
  output logic               dirty,
  output logic [31:0]        peek_addr,
  input  logic [31:0]        peek_rdata,
  output logic               fill_wreq,
  output logic [31:0]        fill_addr,
  output logic [31:0]        fill_wdata,
  l1_line_refill_if.master   mem
);

  state_t             state;
  logic [WORD_W-1:0]  cnt;
  logic [TAG_W-1:0]   miss_tag;
  logic [SET_W-1:0]   miss_set;
  logic [31:0]        peek_hold;

  logic [TAG_W-1:0]   req_tag;
  logic [SET_W-1:0]   req_set;
  logic [31:0]        wb_addr;
  logic [31:0]        rd_addr;
  logic               last_word;
  logic               unused_miss_addr;

  assign req_tag   = miss_addr[31 -: TAG_W];
  assign req_set   = miss_addr[WORD_W+2 +: SET_W];
  assign unused_miss_addr = ^miss_addr[WORD_W+1:0];

  // Victim words come from the line's current identity, refill words from the
  // latched miss identity.
  assign wb_addr   = {my_tag_addr, my_set_addr, cnt, 2'b00};
  assign rd_addr   = {miss_tag, miss_set, cnt, 2'b00};
  assign last_word = (cnt == {WORD_W{1'b1}});

  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign mem.mem_req   = (state == WB) || (state == FILL);
  assign mem.mem_we    = (state == WB);
  assign mem.mem_addr  = (state == WB) ? wb_addr : rd_addr;
  assign mem.mem_wdata = peek_rdata;

  // peek_addr tracks the victim word during WB and freezes afterwards.
  assign peek_addr  = (state == WB) ? wb_addr : peek_hold;

  // The line is written in the same cycle the bus returns the word.
  assign fill_wreq  = (state == FILL) && mem.mem_ack;
  assign fill_addr  = rd_addr;
  assign fill_wdata = mem.mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      valid       <= 1'b0;
      dirty       <= 1'b0;
      my_tag_addr <= '0;
      my_set_addr <= '0;
    end else begin
      if (cpu_wr_hit && (state != FILL) && (state != DONE))
        dirty <= 1'b1;

      case (state)
        IDLE: begin
          if (miss_req) begin
            cnt <= '0;
            if (valid && (dirty || cpu_wr_hit)) begin
              state <= WB;
            end else begin
              state       <= FILL;
              valid       <= 1'b0;
              my_tag_addr <= req_tag;
              my_set_addr <= req_set;
            end
          end
        end
        WB: begin
          if (mem.mem_ack) begin
            cnt <= cnt + WORD_W'(1);
            // The counter wraps to 0 here, so the first refill word follows
            // the last victim word with mem_req held high.
            if (last_word) begin
              state       <= FILL;
              valid       <= 1'b0;
              my_tag_addr <= miss_tag;
              my_set_addr <= miss_set;
            end
          end
        end
        FILL: begin
          if (mem.mem_ack) begin
            cnt <= cnt + WORD_W'(1);
            if (last_word) begin
              state <= DONE;
              valid <= 1'b1;
              dirty <= 1'b0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data-only registers: no reset needed, loaded before they are used.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && miss_req) begin
      miss_tag <= req_tag;
      miss_set <= req_set;
    end
    if (state == WB)
      peek_hold <= wb_addr;
  end

endmodule
